branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Execute-stage branch controller for the pipelined RV32I core.
- Configures the branch comparator by driving its unsigned select, interprets its less/equal flags per funct3, and resolves taken/not-taken.
- Owns a small 2-bit-counter branch history table (BHT) that supplies fetch-stage direction predictions.
- On a mispredict or jump, sequences the redirect of the PC and the flush of the younger pipeline stages.

Parameters:
- BHT_DEPTH, 16, number of BHT entries; power of two, minimum 2.
- FLUSH_CYCLES, 2, cycles flush_o stays high after the redirect cycle; minimum 1.
- XLEN, 32, PC width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ex_valid_i  in  1  instruction in EX is valid.
- ex_is_branch_i  in  1  EX instruction is a conditional branch.
- ex_is_jump_i  in  1  EX instruction is JAL/JALR.
- ex_funct3_i  in  3  branch funct3.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- ex_target_i  in  XLEN  computed branch/jump target.
- ex_pred_taken_i  in  1  prediction carried down from IF.
- br_less_i  in  1  comparator less flag.
- br_equal_i  in  1  comparator equal flag.
- br_unsigned_o  out  1  comparator unsigned select.
- if_pc_i  in  XLEN  fetch PC for prediction lookup.
- pred_taken_o  out  1  direction prediction for if_pc_i.
- redirect_o  out  1  load redirect_pc_o into the PC.
- redirect_pc_o  out  XLEN  corrected fetch address.
- flush_o  out  1  kill IF/ID (and EX input) contents.
- illegal_br_o  out  1  one-cycle pulse: branch with reserved funct3.
- branch_cnt_o  out  32  resolved-branch count.
- mispred_cnt_o  out  32  mispredict count.

Behaviour:
- br_unsigned_o = ex_funct3_i[1]; purely combinational, valid whenever EX holds a branch.
- Taken decode:
  - 000: eq.
  - 001: !eq.
  - 100 and 110: less.
  - 101 and 111: !less.
  - 010 and 011: not taken; illegal_br_o pulses in the next cycle; BHT is not updated.
- "Resolve" = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & state == IDLE. Inputs are ignored in other states.
- Mispredict:
  - Branch: taken != ex_pred_taken_i.
  - Jump: always counts as a mispredict (redirect required).
- Correct PC = taken|jump ? ex_target_i : ex_pc_i + 4, computed modulo 2^XLEN.
- FSM states IDLE, REDIRECT, FLUSH:
  - IDLE, on resolve with mispredict → REDIRECT. The correct PC is registered.
  - REDIRECT (1 cycle): redirect_o=1, flush_o=1, redirect_pc_o = registered PC. Then → FLUSH and the counter is loaded with FLUSH_CYCLES-1.
  - FLUSH: flush_o=1, redirect_o=0. The counter decrements; at 0 → IDLE.
  - Mispredicts presented during REDIRECT/FLUSH are wrong-path instructions and are ignored. This includes the BHT update.
- Latency: redirect_o asserts exactly 1 cycle after the resolving cycle. Total flush window is 1+FLUSH_CYCLES cycles.
- BHT:
  - Index = pc[log2(BHT_DEPTH)+1:2].
  - Each entry is a 2-bit saturating counter; reset value 2'b01.
  - pred_taken_o = entry[if_pc_i index][1], combinational.
  - Update on resolve of a legal branch (not a jump), at the clock edge: taken → increment, saturating at 11; not taken → decrement, saturating at 00.
  - Same-index read during a write returns the pre-update value.
- Reset (async assert, sync release): state=IDLE, redirect_o=0, flush_o=0, redirect_pc_o=0, illegal_br_o=0, all BHT entries 01, counters 0.
- Reset asserted mid-REDIRECT/FLUSH aborts immediately: outputs drop to 0 without waiting for the clock.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - branch_cnt_o increments on every resolve with ex_is_branch_i, illegal included.
  - mispred_cnt_o increments on every resolve with a mispredict, jumps included.
  - Both are 32-bit and wrap from FFFFFFFF to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then if_pc_i=0x0000_0040 → pred_taken_o=0, flush_o=0, redirect_o=0, and all counters are 0.
- BLTU (funct3 110), br_less_i=1, pred=0, pc=0x100, target=0x180:
  - Same cycle: br_unsigned_o=1.
  - Next cycle: redirect_o=1, redirect_pc_o=0x180.
  - flush_o stays high for 3 cycles total, then the FSM is back in IDLE.
- BNE (funct3 001), br_equal_i=1, pred=1, pc=0x200 → redirect_pc_o=0x204. Same pc with pred=0 and not taken → no redirect.
- Resolve taken BEQ at pc=0x40 three times, with no flush between, using pred matching → BHT entry 0 goes 01→10→11→11; pred_taken_o=1 for if_pc_i=0x40.
- During FLUSH, present a JAL with ex_valid_i=1 → ignored: no second redirect, BHT unchanged, mispred_cnt_o unchanged.
- With BR_STATS_EN: funct3 010 branch → illegal_br_o pulses for 1 cycle, branch_cnt_o=1, and mispred_cnt_o increments only if pred=1. Asserting rst_ni=0 during REDIRECT clears flush_o asynchronously.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolver: comparator setup, taken decode, 2-bit BHT and
// redirect/flush sequencing. Define BR_STATS_EN to build the branch/mispredict counters.

module bht_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ctr <= 2'b01;
    else if (inc && ctr != 2'b11)   ctr <= ctr + 2'd1;
    else if (dec && ctr != 2'b00)   ctr <= ctr - 2'd1;
  end
endmodule

module branch_resolve_ctrl #(
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  output logic            br_unsigned_o,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            illegal_br_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t                          state, state_nxt;
  logic   [CNT_W-1:0]              flush_cnt;
  logic   [XLEN-1:0]               redirect_pc;
  logic   [BHT_DEPTH-1:0][1:0]     bht;
  logic                            taken, legal, resolve, mispred, bht_upd;
  logic   [XLEN-1:0]               correct_pc;
  logic   [IDX_W-1:0]              upd_idx, rd_idx;
  logic                            unused_pc_bits;

  assign br_unsigned_o = ex_funct3_i[1];

  always_comb begin
    taken = 1'b0;
    case (ex_funct3_i)
      3'b000:         taken = br_equal_i;
      3'b001:         taken = !br_equal_i;
      3'b100, 3'b110: taken = br_less_i;
      3'b101, 3'b111: taken = !br_less_i;
      default:        taken = 1'b0;
    endcase
  end

  assign legal      = ex_funct3_i[2:1] != 2'b01;
  assign resolve    = ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && state == IDLE;
  // Jumps always redirect since fetch never predicts them.
  assign mispred    = ex_is_jump_i || (taken != ex_pred_taken_i);
  assign correct_pc = (taken || ex_is_jump_i) ? ex_target_i : ex_pc_i + XLEN'(4);
  assign bht_upd    = resolve && ex_is_branch_i && !ex_is_jump_i && legal;

  assign upd_idx = ex_pc_i[IDX_W+1:2];
  assign rd_idx  = if_pc_i[IDX_W+1:2];

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    logic hit;
    assign hit = bht_upd && (upd_idx == IDX_W'(i));
    bht_entry u_entry (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (hit && taken),
      .dec   (hit && !taken),
      .ctr   (bht[i])
    );
  end

  // Combinational read: a same-cycle update is only visible after the edge.
  assign pred_taken_o   = bht[rd_idx][1];
  assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    state_nxt  = state;
    redirect_o = 1'b0;
    flush_o    = 1'b0;
    case (state)
      IDLE:     if (resolve && mispred) state_nxt = REDIRECT;
      REDIRECT: begin
        redirect_o = 1'b1;
        flush_o    = 1'b1;
        state_nxt  = FLUSH;
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_cnt == '0) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cnt    <= '0;
      redirect_pc  <= '0;
      illegal_br_o <= 1'b0;
    end else begin
      if (state == REDIRECT)                     flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - CNT_W'(1);
      if (resolve && mispred) redirect_pc <= correct_pc;
      illegal_br_o <= resolve && ex_is_branch_i && !ex_is_jump_i && !legal;
    end
  end

  assign redirect_pc_o = redirect_pc;

`ifdef BR_STATS_EN
  logic [31:0] branch_cnt, mispred_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && ex_is_branch_i) branch_cnt  <= branch_cnt + 32'd1;
      if (resolve && mispred)        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt_o  = branch_cnt;
  assign mispred_cnt_o = mispred_cnt;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed literal checks plus a randomized run
// compared every cycle against a timeline-based behavioural model.

module tb_branch_resolve_ctrl;
  localparam int BHT_DEPTH    = 16;
  localparam int FLUSH_CYCLES = 2;
  localparam int XLEN         = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_pred_taken_i;
  logic [2:0]      ex_funct3_i;
  logic [XLEN-1:0] ex_pc_i, ex_target_i, if_pc_i, redirect_pc_o;
  logic            br_less_i, br_equal_i, br_unsigned_o, pred_taken_o;
  logic            redirect_o, flush_o, illegal_br_o;
  logic [31:0]     branch_cnt_o, mispred_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  branch_resolve_ctrl #(.BHT_DEPTH(BHT_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i),
    .ex_is_jump_i(ex_is_jump_i), .ex_funct3_i(ex_funct3_i), .ex_pc_i(ex_pc_i),
    .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i), .br_less_i(br_less_i),
    .br_equal_i(br_equal_i), .br_unsigned_o(br_unsigned_o), .if_pc_i(if_pc_i),
    .pred_taken_o(pred_taken_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .illegal_br_o(illegal_br_o), .branch_cnt_o(branch_cnt_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a redirect happens at cycle redir_cyc and flush covers the next FLUSH_CYCLES too.
  longint      cyc, redir_cyc;
  logic [31:0] m_pc, m_bcnt, m_mcnt;
  int          m_bht[BHT_DEPTH];
  logic        m_ill;

  task automatic model_reset();
    cyc = 0; redir_cyc = -1000; m_pc = '0; m_bcnt = '0; m_mcnt = '0; m_ill = 1'b0;
    for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef BR_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  always @(negedge clk_i) begin
    logic e_flush, res, tk, legal, mis;
    int   idx;
    if (!rst_ni) begin
      model_reset();
      chk("rst_redirect", redirect_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_illegal", illegal_br_o, 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_pred", pred_taken_o, 0);
      chk("rst_branch_cnt", branch_cnt_o, 0);
      chk("rst_mispred_cnt", mispred_cnt_o, 0);
    end else begin
      e_flush = (cyc >= redir_cyc) && (cyc <= redir_cyc + FLUSH_CYCLES);
      chk("br_unsigned", br_unsigned_o, ex_funct3_i[1]);
      chk("pred_taken", pred_taken_o, m_bht[(if_pc_i >> 2) % BHT_DEPTH] >= 2);
      chk("redirect", redirect_o, cyc == redir_cyc);
      chk("flush", flush_o, e_flush);
      chk("redirect_pc", redirect_pc_o, m_pc);
      chk("illegal_br", illegal_br_o, m_ill);
      chk("branch_cnt", branch_cnt_o, stat(m_bcnt));
      chk("mispred_cnt", mispred_cnt_o, stat(m_mcnt));
      res   = ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && !e_flush;
      legal = !(ex_funct3_i == 3'd2 || ex_funct3_i == 3'd3);
      tk    = legal && (ex_funct3_i[2] ? (br_less_i ^ ex_funct3_i[0]) : (br_equal_i ^ ex_funct3_i[0]));
      m_ill = 1'b0;
      if (res) begin
        if (ex_is_branch_i) m_bcnt = m_bcnt + 1;
        mis = ex_is_jump_i || (tk != ex_pred_taken_i);
        if (mis) begin
          m_mcnt    = m_mcnt + 1;
          redir_cyc = cyc + 1;
          m_pc      = (tk || ex_is_jump_i) ? ex_target_i : ex_pc_i + 32'd4;
        end
        if (ex_is_branch_i && !ex_is_jump_i && legal) begin
          idx = int'((ex_pc_i >> 2) % BHT_DEPTH);
          if (tk && m_bht[idx] < 3)       m_bht[idx]++;
          else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
        end
        m_ill = ex_is_branch_i && !ex_is_jump_i && !legal;
      end
      cyc++;
    end
  end

  task automatic nxt(); @(posedge clk_i); #1; endtask
  task automatic smp(); @(negedge clk_i); #1; endtask

  task automatic drv(input logic v, input logic br, input logic j, input logic [2:0] f3,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                     input logic less, input logic eq);
    ex_valid_i = v; ex_is_branch_i = br; ex_is_jump_i = j; ex_funct3_i = f3;
    ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pred; br_less_i = less; br_equal_i = eq;
  endtask

  task automatic clr(); drv(0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 0); endtask

  task automatic do_reset(); nxt(); rst_ni = 1'b0; nxt(); nxt(); rst_ni = 1'b1; endtask

  initial begin
    int nfl, nred;
    logic [1:0] kind;
    rst_ni = 1'b0; clr(); if_pc_i = 32'h40;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    smp();
    chk("lit_reset_pred", pred_taken_o, 0);
    chk("lit_reset_flush", flush_o, 0);
    chk("lit_reset_redirect", redirect_o, 0);
    chk("lit_reset_bcnt", branch_cnt_o, 0);
    chk("lit_reset_mcnt", mispred_cnt_o, 0);

    // BLTU taken, predicted not taken
    nxt(); drv(1, 1, 0, 3'b110, 32'h100, 32'h180, 0, 1, 0);
    smp(); chk("lit_bltu_unsigned", br_unsigned_o, 1); chk("lit_bltu_no_early_redir", redirect_o, 0);
    nxt(); clr();
    smp(); chk("lit_bltu_redirect", redirect_o, 1); chk("lit_bltu_pc", redirect_pc_o, 32'h180);
    nfl = int'(flush_o);
    repeat (5) begin nxt(); smp(); nfl += int'(flush_o); end
    chk("lit_bltu_flush_len", nfl, 3);
    chk("lit_bltu_idle", flush_o, 0);

    // BNE not taken, predicted taken -> fall-through
    nxt(); drv(1, 1, 0, 3'b001, 32'h200, 32'h300, 1, 0, 1);
    nxt(); clr();
    smp(); chk("lit_bne_redirect", redirect_o, 1); chk("lit_bne_pc", redirect_pc_o, 32'h204);
    repeat (4) nxt();
    drv(1, 1, 0, 3'b001, 32'h200, 32'h300, 0, 0, 1);
    nxt(); clr();
    smp(); chk("lit_bne_ok_redirect", redirect_o, 0); chk("lit_bne_ok_flush", flush_o, 0);

    // BHT saturation on entry 0
    do_reset(); if_pc_i = 32'h40;
    smp(); chk("lit_bht_init", pred_taken_o, 0);
    nxt(); drv(1, 1, 0, 3'b000, 32'h40, 32'h80, 1, 0, 1);
    smp(); chk("lit_bht_rdw", pred_taken_o, 0);
    nxt(); smp(); chk("lit_bht_10", pred_taken_o, 1);
    nxt();
    nxt(); drv(1, 1, 0, 3'b000, 32'h40, 32'h80, 0, 0, 0);
    nxt(); clr();
    smp(); chk("lit_bht_sat", pred_taken_o, 1); chk("lit_bht_noflush", flush_o, 0);

    // JAL during FLUSH is wrong-path
    nxt(); drv(1, 1, 0, 3'b110, 32'h300, 32'h500, 0, 1, 0);
    nxt(); clr();
    nxt(); drv(1, 0, 1, 3'b000, 32'h304, 32'h900, 0, 0, 0);
    nxt(); clr();
    nred = 0;
    repeat (4) begin nxt(); smp(); nred += int'(redirect_o); end
    chk("lit_jal_ignored", nred, 0);
    chk("lit_jal_pc", redirect_pc_o, 32'h500);
    chk("lit_jal_mcnt", mispred_cnt_o, stat(32'd1));
    chk("lit_jal_bcnt", branch_cnt_o, stat(32'd5));

    // fall-through wraps modulo 2^32
    nxt(); drv(1, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h10, 1, 0, 0);
    nxt(); clr();
    smp(); chk("lit_wrap_pc", redirect_pc_o, 32'h0);
    repeat (4) nxt();

    // reserved funct3, then async reset during REDIRECT
    do_reset();
    nxt(); drv(1, 1, 0, 3'b010, 32'h400, 32'h480, 1, 0, 0);
    smp(); chk("lit_ill_not_yet", illegal_br_o, 0);
    nxt(); clr();
    smp(); chk("lit_ill_pulse", illegal_br_o, 1); chk("lit_ill_redirect", redirect_o, 1);
    chk("lit_ill_pc", redirect_pc_o, 32'h404);
    chk("lit_ill_bcnt", branch_cnt_o, stat(32'd1));
    chk("lit_ill_mcnt", mispred_cnt_o, stat(32'd1));
    #1 rst_ni = 1'b0;
    #1 chk("lit_async_flush", flush_o, 0); chk("lit_async_redirect", redirect_o, 0);
    nxt(); nxt(); rst_ni = 1'b1;

    // randomized run
    repeat (3000) begin
      nxt();
      kind = 2'($urandom_range(0, 3));
      drv(($urandom % 4) != 0, kind < 2, kind == 2, 3'($urandom),
          ($urandom % 32 == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63)) << 2,
          32'($urandom) & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 1'($urandom));
      if_pc_i = 32'($urandom_range(0, 63)) << 2;
    end
    nxt(); clr();
    repeat (5) nxt();
    smp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
